// File: rtl/start_pixel_fetch.sv
// Start-screen pixel fetch: maps screen coordinates onto a half-resolution start
// image ROM and delivers a palette index two clocks later, aligned with valid/syncs.
// Optional blink of a screen rectangle is compiled in with START_BLINK_EN.
module start_pixel_fetch #(
  parameter int IMG_W    = 320,
  parameter int BLINK_X0 = 200,
  parameter int BLINK_X1 = 440,
  parameter int BLINK_Y0 = 360,
  parameter int BLINK_Y1 = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [16:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [3:0]  start_color_index,
  output logic        pix_valid,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [9:0]  H_VIS   = 10'd640;
  localparam logic [9:0]  V_VIS   = 10'd480;
  localparam logic [16:0] IMG_W17 = 17'(IMG_W);

  logic        vis_s;
  logic [16:0] row_base_s;
  logic [16:0] addr_d, addr_q;
  logic        vis1_q, hs1_q, vs1_q;
  logic [3:0]  idx_d, idx_q;
  logic        blank_s;
  logic        pv2_q, hs2_q, vs2_q;

  // Stage-1 address: the image is stored at half resolution in both axes.
  always_comb begin
    vis_s      = valid && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    row_base_s = 17'(v_cnt[9:1]) * IMG_W17;
    if (vis_s) begin
      addr_d = row_base_s + 17'(h_cnt[9:1]);
    end else begin
      addr_d = 17'd0;
    end
  end

`ifdef START_BLINK_EN
  localparam logic [9:0] BX0 = 10'(BLINK_X0);
  localparam logic [9:0] BX1 = 10'(BLINK_X1);
  localparam logic [9:0] BY0 = 10'(BLINK_Y0);
  localparam logic [9:0] BY1 = 10'(BLINK_Y1);

  logic       hit_s, hit1_q;
  logic       vs_prev_q;
  logic [5:0] frame_cnt_d, frame_cnt_q;

  // Hit test uses full screen coordinates; frame count advances on vsync falling edges.
  always_comb begin
    hit_s = (h_cnt >= BX0) && (h_cnt < BX1) && (v_cnt >= BY0) && (v_cnt < BY1);
    if (vs_prev_q && !vsync_in) begin
      frame_cnt_d = frame_cnt_q + 6'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    blank_s = hit1_q && frame_cnt_q[5];
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit1_q      <= 1'b0;
      vs_prev_q   <= 1'b1;
      frame_cnt_q <= 6'd0;
    end else begin
      hit1_q      <= hit_s;
      vs_prev_q   <= vsync_in;
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  always_comb begin
    blank_s = 1'b0;
  end
`endif

  // Stage-2 index: invisible or blinked-out pixels are forced to palette entry 0.
  always_comb begin
    if (vis1_q) begin
      if (blank_s) begin
        idx_d = 4'd0;
      end else begin
        idx_d = rom_data;
      end
    end else begin
      idx_d = 4'd0;
    end
  end

  // Two-stage pipeline; reset drops in-flight pixels and idles the syncs high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= 17'd0;
      vis1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      idx_q  <= 4'd0;
      pv2_q  <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else begin
      addr_q <= addr_d;
      vis1_q <= vis_s;
      hs1_q  <= hsync_in;
      vs1_q  <= vsync_in;
      idx_q  <= idx_d;
      pv2_q  <= vis1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  assign rom_addr          = addr_q;
  assign start_color_index = idx_q;
  assign pix_valid         = pv2_q;
  assign hsync_out         = hs2_q;
  assign vsync_out         = vs2_q;

endmodule

// File: doc/start_pixel_fetch.md
START_PIXEL_FETCH -- requirements
Module: start_pixel_fetch

Interface
REQ-001 SHALL have parameter IMG_W, default 320, meaning stored start image width in pixels.
REQ-002 SHALL have parameters BLINK_X0/BLINK_X1, defaults 200/440, meaning blink rectangle horizontal screen bounds, [X0,X1).
REQ-003 SHALL have parameters BLINK_Y0/BLINK_Y1, defaults 360/400, meaning blink rectangle vertical screen bounds, [Y0,Y1).
REQ-004 SHALL use one clock and a synchronous, active-low reset: clk  in  1  system/pixel clock, rising-edge; rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have h_cnt  in  10  current screen column, 0..799.
REQ-006 SHALL have v_cnt  in  10  current screen row, 0..524.
REQ-007 SHALL have valid  in  1  visible-area flag from the timing generator.
REQ-008 SHALL have hsync_in, vsync_in  in  1 each  active-low sync pulses.
REQ-009 SHALL have rom_addr  out  17  read address to the start-image ROM.
REQ-010 SHALL have rom_data  in  4  palette index returned by the synchronous ROM, one cycle after rom_addr.
REQ-011 SHALL have start_color_index  out  4  palette index for the start color decoder.
REQ-012 SHALL have pix_valid, hsync_out, vsync_out  out  1 each  delayed valid and syncs, aligned to start_color_index.

Function
REQ-013 SHALL treat a pixel as visible only if valid=1 and h_cnt<640 and v_cnt<480.
REQ-014 SHALL register rom_addr = (v_cnt>>1)*IMG_W + (h_cnt>>1) at the edge sampling a visible pixel (stage 1), computed in 17 bits without overflow (max 76799).
REQ-015 SHALL register rom_addr = 0 for non-visible pixels.
REQ-016 SHALL register start_color_index from rom_data at stage 2: total latency 2 clocks from sampled h_cnt/v_cnt to start_color_index.
REQ-017 SHALL force start_color_index = 0 when the stage-2 pixel is non-visible.
REQ-018 SHALL delay visibility, hsync_in, vsync_in through exactly 2 register stages to pix_valid, hsync_out, vsync_out.
REQ-019 SHALL accept a new pixel every clock; no stalls, no backpressure.
REQ-020 SHALL compute the blink-rectangle hit flag at stage 1 from screen coordinates (not halved) and carry it to stage 2.

Reset
REQ-021 SHALL, while rst_n=0 at a rising edge, set rom_addr=0, start_color_index=0, pix_valid=0, hsync_out=1, vsync_out=1, all pipeline registers idle (invisible, syncs 1).
REQ-022 SHALL, on reset asserted mid-frame, discard in-flight pixels; first valid output appears 2 clocks after the first visible sample following rst_n=1.
REQ-023 SHALL clear the frame counter (when compiled in) to 0 on reset.

Configuration
REQ-024 SHALL compile the blink feature only when macro START_BLINK_EN is defined.
REQ-025 With START_BLINK_EN: SHALL keep a 6-bit frame counter incremented on each vsync_in falling edge (sampled previous value 1, current 0), wrapping 63->0.
REQ-026 With START_BLINK_EN: SHALL output start_color_index=0 for visible pixels whose hit flag is set while frame counter bit 5 = 1; otherwise rom_data.
REQ-027 Without START_BLINK_EN: SHALL contain no frame counter or hit logic; start_color_index = rom_data for every visible pixel.

Verification
REQ-028 Reset: hold rst_n=0 three clocks with random inputs -> all outputs at REQ-021 values every cycle.
REQ-029 Addressing: visible (h,v)=(0,0) then (639,479) then (5,3) -> rom_addr 0, 76799, 322 one clock after each sample.
REQ-030 Latency: ROM model returning addr[3:0], drive (h,v)=(7,0) -> start_color_index=3, pix_valid=1, exactly 2 clocks after sample; hsync_out mirrors hsync_in delayed 2.
REQ-031 Blanking: valid=0 or h_cnt=700 with rom_data=4'hF -> start_color_index=0, pix_valid=0 after 2 clocks, rom_addr=0 after 1.
REQ-032 Blink (START_BLINK_EN): after 32 vsync_in falling edges, pixel (300,380) with rom_data=7 -> index 0; pixel (100,380) -> 7; after 64 edges (wrap), (300,380) -> 7.
REQ-033 Reset mid-frame: assert rst_n=0 one clock during a visible run -> outputs zeroed next edge, frame counter 0, valid indices resume 2 clocks after release.
